// File: rtl/cgra_config_sink.sv
// Tile-side CGRA configuration endpoint: decodes one (addr, data) pair per
// cycle into register writes/reads and flags when the config stream is idle.
module cgra_config_sink #(
  parameter logic [15:0] TILE_ID     = 16'h0001,
  parameter int          NUM_REGS    = 8,
  parameter int          IDLE_CYCLES = 4
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [31:0]             config_addr_in,
  input  logic [31:0]             config_data_in,
  output logic [NUM_REGS*32-1:0]  cfg_regs_out,
  output logic [31:0]             read_data_out,
  output logic                    read_valid_out,
  output logic [15:0]             write_count_out,
  output logic                    config_done_out,
  output logic                    illegal_out
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CW = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [1:0] {
    WAIT_FIRST,
    LOADING,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] idle_q, idle_d;

  logic [7:0]    op;
  logic [7:0]    idx;
  logic [IW-1:0] ridx;
  logic          idle;
  logic          match;
  logic          in_range;
  logic          wr_ok;
  logic          rd_op;
  logic          bad;

  logic [31:0]   regs [NUM_REGS];

  assign op       = config_addr_in[31:24];
  assign idx      = config_addr_in[23:16];
  assign ridx     = idx[IW-1:0];
  assign idle     = (config_addr_in == 32'h0);
  assign match    = !idle && (config_addr_in[15:0] == TILE_ID);
  assign in_range = ({1'b0, idx} < 9'(NUM_REGS));
  assign wr_ok    = match && (op == 8'h00) && in_range;
  assign rd_op    = match && (op == 8'h01);
  assign bad      = match && !(((op == 8'h00) || (op == 8'h01)) && in_range);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign cfg_regs_out[32*i +: 32] = regs[i];
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      read_data_out   <= '0;
      read_valid_out  <= 1'b0;
      write_count_out <= '0;
      illegal_out     <= 1'b0;
    end else begin
      read_valid_out <= rd_op;
      if (wr_ok) begin
        regs[ridx] <= config_data_in;
        if (write_count_out != 16'hFFFF)
          write_count_out <= write_count_out + 16'd1;
      end
      if (rd_op)
        read_data_out <= in_range ? regs[ridx] : 32'h0;
      if (bad)
        illegal_out <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= WAIT_FIRST;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
    end
  end

  // Done is entered on the edge that completes the IDLE_CYCLES-th idle cycle
  always_comb begin
    state_d = state_q;
    idle_d  = '0;
    unique case (state_q)
      WAIT_FIRST: begin
        if (wr_ok) state_d = LOADING;
      end
      LOADING: begin
        if (idle) begin
          if (idle_q == CW'(IDLE_CYCLES - 1)) state_d = DONE;
          else idle_d = idle_q + CW'(1);
        end
      end
      DONE: begin
        if (wr_ok) state_d = LOADING;
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  assign config_done_out = (state_q == DONE);

endmodule
